// File: rtl/divremsqrt_iter_fsm_pkg.sv
// Shared definitions for the divide/remainder/sqrt iteration controller.
//   state_t  : controller states (IDLE, BUSY, DONE)
//   FMT_*    : floating-point format encodings carried on FmtE
//   fp_iters : iteration count for an NF-bit fraction at RK bits per cycle
package divremsqrt_iter_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] FMT_S = 2'd0;
   localparam logic [1:0] FMT_D = 2'd1;
   localparam logic [1:0] FMT_H = 2'd2;
   localparam logic [1:0] FMT_Q = 2'd3;

   // ceil((nf + 3) / rk) - 1 : the +3 covers the integer bit plus the
   // guard/round bits the postprocessor needs; the -1 is because the
   // counter counts down to zero inclusively.
   function automatic int fp_iters(input int nf, input int rk);
      return (nf + 3 + rk - 1) / rk - 1;
   endfunction

endpackage

// File: rtl/divremsqrt_iter_fsm_if.sv
// Handshake bundle between the Execute-stage pipeline and the iteration
// controller.
//   master : pipeline side (drives start/stall/flush/format, reads status)
//   slave  : controller side
interface divremsqrt_iter_fsm_if #(
   parameter int DURLEN = 6
);
   logic              FDivStartE;
   logic              StallE;
   logic              StallM;
   logic              FlushE;
   logic [1:0]        FmtE;
   logic              IntDivE;
   logic [DURLEN-1:0] nE;
   logic              SpecialCaseE;
   logic              WZeroE;
   logic              IFDivStartE;
   logic              FDivBusyE;
   logic              FDivDoneE;
   logic [DURLEN-1:0] IterCntE;

   modport master (
      output FDivStartE, StallE, StallM, FlushE, FmtE, IntDivE, nE,
             SpecialCaseE, WZeroE,
      input  IFDivStartE, FDivBusyE, FDivDoneE, IterCntE
   );

   modport slave (
      input  FDivStartE, StallE, StallM, FlushE, FmtE, IntDivE, nE,
             SpecialCaseE, WZeroE,
      output IFDivStartE, FDivBusyE, FDivDoneE, IterCntE
   );
endinterface

// File: rtl/divremsqrt_cyclecalc.sv
// Combinational iteration-count selector.
//   fmt    : FP format (S/D/H/Q)
//   intdiv : integer op; count comes straight from n
//   n      : integer iteration count from the preprocessor
//   cycles : count to load into the iteration counter
module divremsqrt_cyclecalc #(
   parameter int RK     = 2,
   parameter int DURLEN = 6,
   parameter int NF_S   = 23,
   parameter int NF_D   = 52,
   parameter int NF_H   = 10,
   parameter int NF_Q   = 112
) (
   input  logic [1:0]        fmt,
   input  logic              intdiv,
   input  logic [DURLEN-1:0] n,
   output logic [DURLEN-1:0] cycles
);
   import divremsqrt_iter_fsm_pkg::*;

   localparam logic [DURLEN-1:0] CYC_S = DURLEN'(fp_iters(NF_S, RK));
   localparam logic [DURLEN-1:0] CYC_D = DURLEN'(fp_iters(NF_D, RK));
   localparam logic [DURLEN-1:0] CYC_H = DURLEN'(fp_iters(NF_H, RK));
   localparam logic [DURLEN-1:0] CYC_Q = DURLEN'(fp_iters(NF_Q, RK));

   // Sqrt shares the divide count, so only format and intdiv matter.
   always_comb begin
      cycles = CYC_S;
      if (intdiv) begin
         cycles = n;
      end else begin
         case (fmt)
            FMT_S:   cycles = CYC_S;
            FMT_D:   cycles = CYC_D;
            FMT_H:   cycles = CYC_H;
            default: cycles = CYC_Q;
         endcase
      end
   end
endmodule

// File: rtl/divremsqrt_iter_fsm.sv
// Iteration controller for the radix-2^k divide/remainder/sqrt unit.
// Accepts a start request, loads an iteration count, sequences the
// recurrence and raises busy/done to the pipeline stall logic.
//   clk   : core clock
//   reset : asynchronous, active-low
//   bus   : slave side of divremsqrt_iter_fsm_if (start/stall/flush/format
//           in; IFDivStartE/FDivBusyE/FDivDoneE/IterCntE out)
module divremsqrt_iter_fsm #(
   parameter int LOGR      = 2,
   parameter int DIVCOPIES = 1,
   parameter int DURLEN    = 6,
   parameter int NF_S      = 23,
   parameter int NF_D      = 52,
   parameter int NF_H      = 10,
   parameter int NF_Q      = 112
) (
   input  logic                 clk,
   input  logic                 reset,
   divremsqrt_iter_fsm_if.slave bus
);
   import divremsqrt_iter_fsm_pkg::*;

   localparam int RK = LOGR * DIVCOPIES;

   state_t            state_reg, state_next;
   logic [DURLEN-1:0] cnt_reg, cnt_next;
   logic [DURLEN-1:0] cycles;
   logic              accept;

   divremsqrt_cyclecalc #(
      .RK     (RK),
      .DURLEN (DURLEN),
      .NF_S   (NF_S),
      .NF_D   (NF_D),
      .NF_H   (NF_H),
      .NF_Q   (NF_Q)
   ) u_cyclecalc (
      .fmt    (bus.FmtE),
      .intdiv (bus.IntDivE),
      .n      (bus.nE),
      .cycles (cycles)
   );

   assign accept = (state_reg == IDLE) & bus.FDivStartE & ~bus.StallE & ~bus.FlushE;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; flush beats completion, early exit beats count-out.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = bus.SpecialCaseE ? DONE : BUSY;
         BUSY: begin
            if (bus.FlushE)                         state_next = IDLE;
            else if (bus.WZeroE || cnt_reg == '0)   state_next = DONE;
         end
         DONE: if (bus.FlushE || !bus.StallM) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Iteration counter: loaded on every accept (special cases included),
   // counts down while BUSY and sticks at zero. Flush leaves it alone.
   always_comb begin
      cnt_next = cnt_reg;
      if (accept)
         cnt_next = cycles;
      else if (state_reg == BUSY && cnt_reg != '0)
         cnt_next = cnt_reg - DURLEN'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_reg <= '0;
      else        cnt_reg <= cnt_next;
   end

   // Outputs; busy covers the accept cycle so the pipeline stalls at once.
   always_comb begin
      bus.IFDivStartE = accept & ~bus.SpecialCaseE;
      bus.FDivBusyE   = (state_reg == BUSY) | (accept & ~bus.SpecialCaseE);
      bus.FDivDoneE   = (state_reg == DONE);
      bus.IterCntE    = cnt_reg;
   end
endmodule
